// File: rtl/arp_ctrl.sv
// ---------------------------------------------------------------------------
// arp_ctrl -- ARP protocol controller with a single-entry peer cache.
//
// Sits beside an ARP frame rx/tx block on the GMII clock. It does two jobs:
//   * answers ARP requests addressed to the board (one-deep pending slot,
//     newest request wins), and
//   * resolves a user-supplied IP by broadcasting ARP requests, retrying
//     after TIMEOUT_CYC cycles up to MAX_RETRY transmissions, and stores the
//     answer in a single-entry cache.
// Replies to the network take priority over outgoing requests. The answer
// timeout keeps running while a reply is being transmitted.
//
// Parameters:
//   TIMEOUT_CYC  cycles to wait for an ARP reply before retransmitting
//   MAX_RETRY    request transmissions per resolve before failing (1..15)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   arp_rx_done               pulse: ARP frame for the board IP received
//   arp_rx_type               0 = request, 1 = reply (valid with arp_rx_done)
//   src_mac, src_ip           sender addresses (valid with arp_rx_done)
//   tx_done                   pulse: ARP frame transmission finished
//   arp_tx_en                 pulse: start an ARP transmission
//   arp_tx_type               0 = request, 1 = reply
//   des_mac, des_ip           target addresses, stable from arp_tx_en to tx_done
//   resolve_req, resolve_ip   user request to resolve an IP
//   resolve_busy              a resolve is in progress
//   resolve_ok, resolve_fail  completion pulses
//   peer_valid/mac/ip         single-entry ARP cache
//
// Build option:
//   ARP_CACHE_LEARN_EN  when defined, every received ARP request also loads
//                       its sender into the cache.
// ---------------------------------------------------------------------------
module arp_ctrl #(
    parameter int TIMEOUT_CYC = 125_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    output logic        resolve_busy,
    output logic        resolve_ok,
    output logic        resolve_fail,
    output logic        peer_valid,
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TX_REPLY,
        WAIT_REPLY_DONE,
        TX_REQ,
        WAIT_REQ_DONE,
        WAIT_ANSWER
    } state_t;

    state_t        state_reg;

    // one-deep slot for an ARP request that still needs a reply
    logic          pend_valid_reg;
    logic [47:0]   pend_mac_reg;
    logic [31:0]   pend_ip_reg;

    // resolve bookkeeping
    logic [31:0]   target_ip_reg;
    logic [3:0]    retry_cnt_reg;
    logic          req_out_reg;     // request sent, waiting for the answer
    logic [TW-1:0] tmo_cnt_reg;
    logic          ok_pend_reg;     // delays resolve_ok one cycle behind the cache load

    logic          rx_request;
    logic          match_reply;
    logic          timeout_hit;
    logic          retry_left;

    always_comb begin
        rx_request  = arp_rx_done && !arp_rx_type;
        match_reply = arp_rx_done && arp_rx_type && resolve_busy &&
                      (src_ip == target_ip_reg);
        timeout_hit = req_out_reg && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
        retry_left  = retry_cnt_reg < 4'(MAX_RETRY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            arp_tx_en      <= 1'b0;
            arp_tx_type    <= 1'b0;
            des_mac        <= '0;
            des_ip         <= '0;
            resolve_busy   <= 1'b0;
            resolve_ok     <= 1'b0;
            resolve_fail   <= 1'b0;
            peer_valid     <= 1'b0;
            peer_mac       <= '0;
            peer_ip        <= '0;
            pend_valid_reg <= 1'b0;
            pend_mac_reg   <= '0;
            pend_ip_reg    <= '0;
            target_ip_reg  <= '0;
            retry_cnt_reg  <= '0;
            req_out_reg    <= 1'b0;
            tmo_cnt_reg    <= '0;
            ok_pend_reg    <= 1'b0;
        end else begin
            arp_tx_en    <= 1'b0;
            resolve_fail <= 1'b0;
            resolve_ok   <= ok_pend_reg;
            ok_pend_reg  <= 1'b0;

            if (req_out_reg) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end

            if (resolve_req && !resolve_busy) begin
                target_ip_reg <= resolve_ip;
                resolve_busy  <= 1'b1;
                retry_cnt_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (pend_valid_reg) begin
                        state_reg <= TX_REPLY;
                    end else if (req_out_reg) begin
                        state_reg <= WAIT_ANSWER;
                    end else if (resolve_busy) begin
                        state_reg <= TX_REQ;
                    end
                end

                TX_REPLY: begin
                    arp_tx_en      <= 1'b1;
                    arp_tx_type    <= 1'b1;
                    des_mac        <= pend_mac_reg;
                    des_ip         <= pend_ip_reg;
                    pend_valid_reg <= 1'b0;
                    state_reg      <= WAIT_REPLY_DONE;
                end

                WAIT_REPLY_DONE: begin
                    // IDLE hands back to WAIT_ANSWER if a request is still out
                    if (tx_done) begin
                        state_reg <= IDLE;
                    end
                end

                TX_REQ: begin
                    arp_tx_en     <= 1'b1;
                    arp_tx_type   <= 1'b0;
                    des_mac       <= 48'hFFFF_FFFF_FFFF;
                    des_ip        <= target_ip_reg;
                    retry_cnt_reg <= retry_cnt_reg + 4'd1;
                    state_reg     <= WAIT_REQ_DONE;
                end

                WAIT_REQ_DONE: begin
                    if (tx_done) begin
                        // A zero retry count means the resolve was already
                        // answered (and possibly replaced by a fresh one that
                        // has sent nothing yet), so this tx_done is dropped.
                        if (resolve_busy && (retry_cnt_reg != 4'd0) && !match_reply) begin
                            req_out_reg <= 1'b1;
                            tmo_cnt_reg <= '0;
                            state_reg   <= WAIT_ANSWER;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                WAIT_ANSWER: begin
                    if (pend_valid_reg) begin
                        state_reg <= TX_REPLY;
                    end else if (!req_out_reg) begin
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase

            // A matching reply beats a coincident timeout.
            if (match_reply) begin
                peer_mac     <= src_mac;
                peer_ip      <= src_ip;
                peer_valid   <= 1'b1;
                ok_pend_reg  <= 1'b1;
                resolve_busy <= 1'b0;
                req_out_reg  <= 1'b0;
            end else if (timeout_hit) begin
                req_out_reg <= 1'b0;
                if (!retry_left) begin
                    resolve_busy <= 1'b0;
                    resolve_fail <= 1'b1;
                end
            end

            // Placed after the FSM so a request arriving while the previous
            // one is being answered re-arms the slot instead of being lost.
            if (rx_request) begin
                pend_valid_reg <= 1'b1;
                pend_mac_reg   <= src_mac;
                pend_ip_reg    <= src_ip;
`ifdef ARP_CACHE_LEARN_EN
                peer_mac       <= src_mac;
                peer_ip        <= src_ip;
                peer_valid     <= 1'b1;
`else
`endif
            end
        end
    end

endmodule

// File: doc/arp_ctrl.md
ARP_CTRL -- requirements
Module: arp_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 125_000_000, cycles to wait for an ARP reply before retry.
REQ-002 SHALL have parameter MAX_RETRY, default 3, request transmissions per resolve before failing (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock shared with the GMII tx/rx side of the ARP block.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port arp_rx_done  input  1  one-cycle pulse, ARP frame addressed to board IP received.
REQ-006 SHALL have port arp_rx_type  input  1  type of received frame, 0 = request, 1 = reply; valid with arp_rx_done.
REQ-007 SHALL have ports src_mac  input  48  and src_ip  input  32  sender addresses, valid with arp_rx_done.
REQ-008 SHALL have port tx_done  input  1  one-cycle pulse, ARP frame transmission finished.
REQ-009 SHALL have port arp_tx_en  output  1  one-cycle pulse starting an ARP transmission.
REQ-010 SHALL have ports arp_tx_type  output  1  (0 request, 1 reply), des_mac  output  48  and des_ip  output  32  target addresses, held stable from the arp_tx_en pulse to tx_done.
REQ-011 SHALL have ports resolve_req  input  1  (pulse) and resolve_ip  input  32  user request to resolve an IP.
REQ-012 SHALL have ports resolve_busy  output  1, resolve_ok  output  1  (pulse) and resolve_fail  output  1  (pulse).
REQ-013 SHALL have ports peer_valid  output  1, peer_mac  output  48  and peer_ip  output  32  single-entry ARP cache.

Function
REQ-014 SHALL implement states IDLE, TX_REPLY, WAIT_REPLY_DONE, TX_REQ, WAIT_REQ_DONE, WAIT_ANSWER.
REQ-015 SHALL latch src_mac/src_ip into a one-deep reply-pending register on arp_rx_done with arp_rx_type = 0, in any state; a newer request overwrites an unserved one.
REQ-016 SHALL on resolve_req while resolve_busy = 0 latch resolve_ip, set resolve_busy, clear the retry count; SHALL ignore resolve_req while resolve_busy = 1.
REQ-017 SHALL from IDLE go to TX_REPLY if a reply is pending, else to TX_REQ if a resolve is active and no request is outstanding; reply has priority.
REQ-018 SHALL in TX_REPLY pulse arp_tx_en for one cycle with arp_tx_type = 1 and des_mac/des_ip = pending addresses, clear pending, then enter WAIT_REPLY_DONE.
REQ-019 SHALL in TX_REQ pulse arp_tx_en with arp_tx_type = 0, des_mac = 48'hFFFFFFFFFFFF, des_ip = latched resolve_ip, increment the retry count, then enter WAIT_REQ_DONE.
REQ-020 SHALL leave WAIT_REPLY_DONE on tx_done to IDLE (resuming WAIT_ANSWER if a request is outstanding), and WAIT_REQ_DONE on tx_done to WAIT_ANSWER with the timeout counter cleared.
REQ-021 SHALL keep the timeout counter running while a request is outstanding, including while serving a reply.
REQ-022 SHALL on arp_rx_done with arp_rx_type = 1 and src_ip = resolve_ip while a resolve is outstanding: load peer_mac/peer_ip, set peer_valid, pulse resolve_ok one cycle later, clear resolve_busy, return to IDLE.
REQ-023 SHALL on timeout counter reaching TIMEOUT_CYC-1 retransmit (via IDLE) if retry count < MAX_RETRY, else pulse resolve_fail, clear resolve_busy, leave cache unchanged.
REQ-024 SHALL ignore replies whose src_ip differs from resolve_ip, or arriving with no resolve outstanding.
REQ-025 SHALL treat a matching reply arriving in WAIT_REQ_DONE as success, discarding the subsequent tx_done.
REQ-026 SHALL never assert resolve_ok and resolve_fail in the same cycle; success wins if the timeout and a matching reply coincide.

Reset
REQ-027 SHALL on rst force state IDLE and all outputs to 0 (arp_tx_en, arp_tx_type, des_mac, des_ip, resolve_busy, resolve_ok, resolve_fail, peer_valid, peer_mac, peer_ip), clear pending reply, counters and resolve.
REQ-028 SHALL abort an in-progress transmit wait or resolve on rst with no resolve_ok/resolve_fail pulse afterward.

Configuration
REQ-029 SHALL with macro ARP_CACHE_LEARN_EN defined also load the cache (peer_mac/peer_ip, peer_valid = 1) from every received ARP request's sender, without affecting resolve state.
REQ-030 SHALL without ARP_CACHE_LEARN_EN update the cache only per REQ-022.

Verification
REQ-031 Request from 192.168.1.102 / 02:00:00:00:00:01 in IDLE -> arp_tx_en within 2 cycles, type 1, des_mac 02:00:00:00:00:01, des_ip C0A80166.
REQ-032 resolve_req ip C0A80166, tx_done, reply from that IP with MAC 02:00:00:00:00:07 -> broadcast request, resolve_ok, peer_mac 020000000007, peer_valid 1.
REQ-033 TIMEOUT_CYC = 100, MAX_RETRY = 3, no reply -> 3 requests spaced ~100 cycles, then one resolve_fail, resolve_busy 0.
REQ-034 Request received during WAIT_ANSWER -> reply sent, later matching reply still yields resolve_ok.
REQ-035 rst asserted in WAIT_REQ_DONE -> all outputs 0 immediately, no arp_tx_en until new stimulus.
REQ-036 With ARP_CACHE_LEARN_EN, incoming request from C0A80165 -> peer_ip C0A80165, peer_valid 1; without it, peer_valid stays 0.
